// File: rtl/pif_mem_pkg.sv
// Shared types and helpers for the PIF memory controller: FSM state encoding,
// default ROM/command word locations and big-endian byte-lane access.
package pif_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LINK_RD,
    LINK_WR,
    CPU_RD,
    CPU_RMW_RD,
    CPU_RMW_WR,
    DONE
  } state_t;

  localparam logic [8:0] ROM_TOP_DEF  = 9'h1EF;
  localparam logic [8:0] CMD_WORD_DEF = 9'h1FF;

  // Lane 0 is the most significant byte of the word.
  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] sel,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (sel)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pif_mem_if.sv
// Link-side word port, CPU-side byte port and command interrupt of the PIF
// memory controller; slave is the controller, master the requesters.
interface pif_mem_if;
  logic        link_req;
  logic        link_wren;
  logic [8:0]  link_addr;
  logic [31:0] link_wdata;
  logic        link_ack;
  logic [31:0] link_rdata;
  logic        cpu_req;
  logic        cpu_wren;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        rom_lock;
  logic        cmd_irq;
  logic        cmd_irq_clr;

  modport slave (
    input  link_req, link_wren, link_addr, link_wdata,
    output link_ack, link_rdata,
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  rom_lock, cmd_irq_clr,
    output cmd_irq
  );

  modport master (
    output link_req, link_wren, link_addr, link_wdata,
    input  link_ack, link_rdata,
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output rom_lock, cmd_irq_clr,
    input  cmd_irq
  );
endinterface

// File: rtl/pif_mem_ram.sv
// 512x32 single-port synchronous RAM, read-before-write, one-cycle read latency.
// No reset: contents survive controller reset.
module pif_mem_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [512];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pif_mem_arbiter.sv
// PIF memory controller: arbitrates link word and CPU byte accesses onto the
// PIF RAM, protects ROM from link writes, raises cmd_irq. Optional PIF_ROM_LOCK_EN.
module pif_mem_arbiter
  import pif_mem_pkg::*;
#(
  parameter logic [8:0] ROM_TOP  = ROM_TOP_DEF,
  parameter logic [8:0] CMD_WORD = CMD_WORD_DEF
) (
  input  logic      clk,
  input  logic      reset_l,
  pif_mem_if.slave  bus
);

  state_t      state, state_nxt;
  logic        last_link;
  logic        grant_link, grant_cpu;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [8:0]  cpu_word;
  logic [1:0]  cpu_lane;
  logic [31:0] link_rd_word;
  logic        cmd_set;
  logic        link_ack, cpu_ack, cmd_irq;
  logic [31:0] link_rdata;
  logic [7:0]  cpu_rdata;

  assign cpu_word = bus.cpu_addr[10:2];
  assign cpu_lane = bus.cpu_addr[1:0];

  pif_mem_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM address is driven by the winner already in IDLE, so read data is
  // available in LINK_RD/CPU_RD and can be registered with the ack one cycle later.
  always_comb begin
    state_nxt  = state;
    grant_link = 1'b0;
    grant_cpu  = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = bus.link_addr;
    ram_wdata  = bus.link_wdata;
    case (state)
      IDLE: begin
        if (bus.link_req && bus.cpu_req) begin
          if (last_link) grant_cpu = 1'b1;
          else           grant_link = 1'b1;
        end else if (bus.link_req) begin
          grant_link = 1'b1;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
        end
        if (grant_link) begin
          state_nxt = bus.link_wren ? LINK_WR : LINK_RD;
        end else if (grant_cpu) begin
          state_nxt = bus.cpu_wren ? CPU_RMW_RD : CPU_RD;
          ram_addr  = cpu_word;
        end
      end
      LINK_RD: state_nxt = DONE;
      LINK_WR: begin
        ram_we    = (bus.link_addr > ROM_TOP);
        state_nxt = DONE;
      end
      CPU_RD: begin
        ram_addr  = cpu_word;
        state_nxt = DONE;
      end
      CPU_RMW_RD: begin
        ram_addr  = cpu_word;
        state_nxt = CPU_RMW_WR;
      end
      CPU_RMW_WR: begin
        ram_addr  = cpu_word;
        ram_we    = 1'b1;
        ram_wdata = lane_put(ram_rdata, cpu_lane, bus.cpu_wdata);
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PIF_ROM_LOCK_EN
  assign link_rd_word = (bus.rom_lock && (bus.link_addr <= ROM_TOP)) ? '0 : ram_rdata;
`else
  logic unused_rom_lock;
  assign unused_rom_lock = bus.rom_lock;
  assign link_rd_word    = ram_rdata;
`endif

  assign cmd_set = (state == LINK_WR) && (bus.link_addr == CMD_WORD) &&
                   (bus.link_wdata[7:0] != 8'h00);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      last_link  <= 1'b0;
      link_ack   <= 1'b0;
      cpu_ack    <= 1'b0;
      link_rdata <= '0;
      cpu_rdata  <= '0;
      cmd_irq    <= 1'b0;
    end else begin
      state    <= state_nxt;
      link_ack <= (state == LINK_RD) || (state == LINK_WR);
      cpu_ack  <= (state == CPU_RD) || (state == CPU_RMW_WR);
      if (grant_link)     last_link <= 1'b1;
      else if (grant_cpu) last_link <= 1'b0;
      if (state == LINK_RD) link_rdata <= link_rd_word;
      if (state == CPU_RD)  cpu_rdata  <= lane_get(ram_rdata, cpu_lane);
      if (cmd_set)              cmd_irq <= 1'b1;
      else if (bus.cmd_irq_clr) cmd_irq <= 1'b0;
    end
  end

  assign bus.link_ack   = link_ack;
  assign bus.link_rdata = link_rdata;
  assign bus.cpu_ack    = cpu_ack;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cmd_irq    = cmd_irq;

endmodule

// File: tb/tb_pif_mem_arbiter.sv
// Directed bench for pif_mem_arbiter: latency, ROM protection, byte lanes,
// cmd_irq set/clear priority, fair arbitration, ROM lock and mid-transaction reset.
module tb_pif_mem_arbiter;

  logic clk = 1'b0;
  logic reset_l;
  int   passes = 0;
  int   fails  = 0;
  int   total  = 0;

  pif_mem_if bus ();

  pif_mem_arbiter dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic link_xfer(input logic wr, input logic [8:0] a, input logic [31:0] d,
                           input logic clr_in_wr, output logic [31:0] rd,
                           output int lat, output logic irq);
    bus.link_req   = 1'b1;
    bus.link_wren  = wr;
    bus.link_addr  = a;
    bus.link_wdata = d;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      bus.cmd_irq_clr = clr_in_wr && (lat == 1);
      if (bus.link_ack) break;
    end
    rd  = bus.link_rdata;
    irq = bus.cmd_irq;
    bus.link_req    = 1'b0;
    bus.cmd_irq_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cpu_xfer(input logic wr, input logic [10:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    bus.cpu_req   = 1'b1;
    bus.cpu_wren  = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (bus.cpu_ack) break;
    end
    rd = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd32;
    logic [7:0]  rd8;
    logic        irq;
    int          lat;
    logic [7:0]  grant [4];
    int          gcyc  [4];
    int          n;
    logic        seen;
    logic [7:0]  lane_dat [4];
    logic [31:0] exp_rom0;

    bus.link_req = 0; bus.link_wren = 0; bus.link_addr = '0; bus.link_wdata = '0;
    bus.cpu_req = 0; bus.cpu_wren = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.rom_lock = 0; bus.cmd_irq_clr = 0;
    reset_l = 1'b1;
    #2 reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_link_ack", {31'b0, bus.link_ack}, 32'h0);
    check("rst_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
    check("rst_cmd_irq", {31'b0, bus.cmd_irq}, 32'h0);
    check("rst_link_rdata", bus.link_rdata, 32'h0);
    check("rst_cpu_rdata", {24'b0, bus.cpu_rdata}, 32'h0);
    reset_l = 1'b1;
    @(posedge clk); #1;

    // CPU byte writes into PIF RAM, then link word read
    lane_dat[0] = 8'h11; lane_dat[1] = 8'h22; lane_dat[2] = 8'h33; lane_dat[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cpu_xfer(1'b1, 11'h7C0 + 11'(i), lane_dat[i], rd8, lat);
      check("cpu_wr_lat", lat, 3);
    end
    link_xfer(1'b0, 9'h1F0, '0, 1'b0, rd32, lat, irq);
    check("link_rd_lat", lat, 2);
    check("link_rd_ram", rd32, 32'h11223344);
    check("link_rdata_held", bus.link_rdata, 32'h11223344);

    // ROM word loaded by CPU, link write to ROM dropped
    lane_dat[0] = 8'hA5; lane_dat[1] = 8'h5A; lane_dat[2] = 8'hC3; lane_dat[3] = 8'h3C;
    for (int i = 0; i < 4; i++) cpu_xfer(1'b1, 11'h040 + 11'(i), lane_dat[i], rd8, lat);
    link_xfer(1'b1, 9'h010, 32'hDEADBEEF, 1'b0, rd32, lat, irq);
    check("link_wr_rom_lat", lat, 2);
    cpu_xfer(1'b0, 11'h040, 8'h00, rd8, lat);
    check("cpu_rd_lat", lat, 2);
    check("cpu_rd_rom_b0", {24'b0, rd8}, 32'hA5);
    cpu_xfer(1'b0, 11'h043, 8'h00, rd8, lat);
    check("cpu_rd_rom_b3", {24'b0, rd8}, 32'h3C);
    link_xfer(1'b0, 9'h010, '0, 1'b0, rd32, lat, irq);
    check("link_rd_rom_unlocked", rd32, 32'hA55AC33C);

    // Command interrupt
    cpu_xfer(1'b1, 11'h7FF, 8'h80, rd8, lat);
    check("irq_cpu_wr_no_set", {31'b0, bus.cmd_irq}, 32'h0);
    link_xfer(1'b1, 9'h1FF, 32'h00000100, 1'b0, rd32, lat, irq);
    check("irq_zero_byte_no_set", {31'b0, irq}, 32'h0);
    link_xfer(1'b1, 9'h1FF, 32'h00000001, 1'b0, rd32, lat, irq);
    check("irq_set_with_ack", {31'b0, irq}, 32'h1);
    check("link_wr_ram_lat", lat, 2);
    link_xfer(1'b1, 9'h1FF, 32'h00000001, 1'b1, rd32, lat, irq);
    check("irq_set_beats_clr", {31'b0, irq}, 32'h1);
    bus.cmd_irq_clr = 1'b1;
    @(posedge clk); #1;
    bus.cmd_irq_clr = 1'b0;
    check("irq_lone_clr", {31'b0, bus.cmd_irq}, 32'h0);
    link_xfer(1'b0, 9'h1FF, '0, 1'b0, rd32, lat, irq);
    check("cmd_word_stored", rd32, 32'h00000001);

    // ROM read lockout
    lane_dat[0] = 8'h01; lane_dat[1] = 8'h02; lane_dat[2] = 8'h03; lane_dat[3] = 8'h04;
    for (int i = 0; i < 4; i++) cpu_xfer(1'b1, 11'h000 + 11'(i), lane_dat[i], rd8, lat);
    bus.rom_lock = 1'b1;
`ifdef PIF_ROM_LOCK_EN
    exp_rom0 = 32'h0;
`else
    exp_rom0 = 32'h01020304;
`endif
    link_xfer(1'b0, 9'h000, '0, 1'b0, rd32, lat, irq);
    check("lock_rom_rd", rd32, exp_rom0);
    link_xfer(1'b0, 9'h1F0, '0, 1'b0, rd32, lat, irq);
    check("lock_ram_rd", rd32, 32'h11223344);
    cpu_xfer(1'b0, 11'h000, 8'h00, rd8, lat);
    check("lock_cpu_rd", {24'b0, rd8}, 32'h01);
    bus.rom_lock = 1'b0;

    // Both requesters held: last grant was CPU, so link first, then alternate
    bus.link_req = 1'b1; bus.link_wren = 1'b0; bus.link_addr = 9'h1F0;
    bus.cpu_req  = 1'b1; bus.cpu_wren  = 1'b0; bus.cpu_addr  = 11'h7C1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(posedge clk); #1;
      if (bus.link_ack) begin
        grant[n] = "L"; gcyc[n] = c;
        check("alt_link_rdata", bus.link_rdata, 32'h11223344);
        n++;
      end else if (bus.cpu_ack) begin
        grant[n] = "C"; gcyc[n] = c;
        check("alt_cpu_rdata", {24'b0, bus.cpu_rdata}, 32'h22);
        n++;
      end
    end
    bus.link_req = 1'b0; bus.cpu_req = 1'b0;
    check("alt_count", n, 4);
    for (int i = 0; i < n; i++) begin
      check("alt_grant", {24'b0, grant[i]}, (i % 2 == 0) ? 32'h4C : 32'h43);
      if (i > 0) check("alt_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset during CPU_RMW_RD
    link_xfer(1'b1, 9'h1F1, 32'hCAFEF00D, 1'b0, rd32, lat, irq);
    cpu_xfer(1'b0, 11'h7C4, 8'h00, rd8, lat);
    check("pre_rst_cpu_rd", {24'b0, rd8}, 32'hCA);
    bus.cpu_req = 1'b1; bus.cpu_wren = 1'b1; bus.cpu_addr = 11'h7C4; bus.cpu_wdata = 8'h99;
    @(posedge clk); #1;
    reset_l = 1'b0;
    #1;
    bus.cpu_req = 1'b0;
    check("abort_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
    check("abort_link_ack", {31'b0, bus.link_ack}, 32'h0);
    check("abort_link_rdata", bus.link_rdata, 32'h0);
    check("abort_cpu_rdata", {24'b0, bus.cpu_rdata}, 32'h0);
    check("abort_cmd_irq", {31'b0, bus.cmd_irq}, 32'h0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | bus.cpu_ack;
    end
    reset_l = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | bus.cpu_ack;
    end
    check("abort_no_ack", {31'b0, seen}, 32'h0);
    link_xfer(1'b0, 9'h1F1, '0, 1'b0, rd32, lat, irq);
    check("abort_word_kept", rd32, 32'hCAFEF00D);
    check("post_rst_lat", lat, 2);
    cpu_xfer(1'b0, 11'h7C4, 8'h00, rd8, lat);
    check("post_rst_cpu_rd", {24'b0, rd8}, 32'hCA);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pif_mem_arbiter.md
# pif_mem_arbiter

Clock-`clk` PIF memory controller that sits directly downstream of the RCP serial-link interface. It owns the 512×32 PIF memory: words 0x000–0x1EF are boot ROM and words 0x1F0–0x1FF are the 64-byte PIF RAM. It serialises word accesses from the link side with byte accesses from the PIF CPU, protects the ROM region, and raises a command interrupt when the RCP writes a non-zero PIF command byte.

## Interface
Parameters:
- `ROM_TOP`, default 9'h1EF: last ROM word; link writes at or below it are discarded.
- `CMD_WORD`, default 9'h1FF: word holding the PIF command byte in bits [7:0].

Ports:
- `clk` in 1: block clock.
- `reset_l` in 1: reset, asynchronous, active-low.
- `link_req` in 1: link request, level, held until `link_ack`.
- `link_wren` in 1: 1 = write, 0 = read.
- `link_addr` in 9: word address.
- `link_wdata` in 32: write word.
- `link_ack` out 1: one-cycle completion pulse.
- `link_rdata` out 32: read word, valid while `link_ack` = 1, held afterwards.
- `cpu_req` in 1: CPU request, level, held until `cpu_ack`.
- `cpu_wren` in 1: 1 = byte write.
- `cpu_addr` in 11: byte address, big-endian; byte 0 is bits [31:24].
- `cpu_wdata` in 8: write byte.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read byte, held after ack.
- `rom_lock` in 1: ROM read lockout (see Configuration).
- `cmd_irq` out 1: command pending, sticky.
- `cmd_irq_clr` in 1: clears `cmd_irq`.

## Operation
- FSM states: IDLE, LINK_RD, LINK_WR, CPU_RD, CPU_RMW_RD, CPU_RMW_WR, DONE.
- IDLE arbitration:
  - Only `link_req`: go to link state.
  - Only `cpu_req`: go to CPU state.
  - Both: link wins, unless the previous grant was link and CPU was waiting. In that case CPU wins, so grants alternate.
- LINK_RD: RAM read issued; next cycle `link_rdata` is registered and `link_ack` pulses (DONE).
- LINK_WR:
  - Address > `ROM_TOP`: the word is written.
  - Address ≤ `ROM_TOP`: the write is dropped but still acked.
- CPU_RD: read word `cpu_addr[10:2]`; select the byte by `cpu_addr[1:0]` (0 selects bits [31:24]).
- CPU write is read-modify-write:
  - CPU_RMW_RD reads the word.
  - CPU_RMW_WR merges `cpu_wdata` into the addressed lane and writes it.
  - The CPU may write any address, ROM included (boot image load).
- DONE: the ack is high and no request is sampled. The requester must drop `req` by the following cycle, when the FSM is back in IDLE.
- `cmd_irq`:
  - Set by a link write to `CMD_WORD` with `link_wdata[7:0]` ≠ 0.
  - Cleared by `cmd_irq_clr`; if set and clear happen in the same cycle, set wins.
  - CPU writes never set it.
- Memory contents are not affected by reset.
- Reset mid-transaction aborts it: no ack, and any pending write is lost.

## Timing
- Reset values:
  - `link_ack`, `cpu_ack`, `cmd_irq`: 0.
  - `link_rdata`: 32'h0.
  - `cpu_rdata`: 8'h0.
  - FSM: IDLE.
- Latencies, with the request accepted in cycle T (IDLE):
  - Link read: ack at T+2.
  - Link write: ack at T+2.
  - CPU read: ack at T+2.
  - CPU write: ack at T+3.
- Back-to-back throughput from one requester: one transaction per 3 cycles (reads), 4 cycles (CPU writes).
- `cmd_irq` rises the cycle after the qualifying write's RAM write cycle, coincident with `link_ack`.
- Address width rules:
  - `link_addr` is a full 9-bit word address, with no wrap.
  - `cpu_addr[10:2]` is the word address.

## Configuration
- `PIF_ROM_LOCK_EN` defined:
  - While `rom_lock` = 1, link reads with address ≤ `ROM_TOP` return 32'h0.
  - RAM-region reads and all CPU reads are unaffected.
  - `rom_lock` is sampled in the LINK_RD cycle.
- Not defined: `rom_lock` is ignored and link reads of ROM return the stored data.

## Structure
- Shared package `pif_mem_pkg`:
  - FSM state enum.
  - Defaults for `ROM_TOP` and `CMD_WORD`.
  - Byte-lane select function (big-endian).
- Sub-module `pif_mem_ram`: 512×32 single-port synchronous RAM with 1-cycle read latency. A single port suffices because the FSM serialises all access.

## Test plan
- CPU writes bytes 0x11, 0x22, 0x33, 0x44 to byte addresses 0x7C0–0x7C3, then a link read of word 0x1F0 → `link_rdata` = 32'h11223344, ack at T+2.
- Link write of 32'hDEADBEEF to word 0x010 → acked; CPU read of byte address 0x040 returns the prior ROM byte, not 0xDE.
- Link write of 32'h00000001 to 0x1FF → `cmd_irq` = 1.
  - `cmd_irq_clr` pulsed in the same cycle as a second such write → `cmd_irq` stays 1.
  - A later lone clear → 0.
- `link_req` and `cpu_req` held continuously → grants alternate link, CPU, link, CPU; neither starves.
- With `PIF_ROM_LOCK_EN` and `rom_lock` = 1, link read of 0x000 → 32'h0; link read of 0x1F0 → stored data. Without the macro → ROM data.
- `reset_l` asserted during CPU_RMW_RD → no `cpu_ack`; all outputs 0; target word unchanged; the next request completes normally.
